// File: rtl/ipv4_daddr_extract_pkg.sv
// ipv4_pkg: shared constants and types for the IPv4 destination-address tap.
//   - ethertype constants
//   - frame byte offsets (Ethernet type, IPv4 header, IPv4 daddr, VLAN tag size)
//   - parser state encoding and the registered result record
package ipv4_pkg;

    // Bytes per 256-bit AXI4-Stream beat.
    localparam int unsigned BEAT_BYTES     = 32;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_VLAN = 16'h8100;

    // Frame byte offsets (untagged frame).
    localparam int unsigned ETH_TYPE_OFF   = 12;
    localparam int unsigned IP_HDR_OFF     = 14;
    localparam int unsigned IP_HDR_BYTES   = 20;
    localparam int unsigned IP_DADDR_OFF   = 30;
    // Extra bytes inserted by one 802.1Q tag.
    localparam int unsigned VLAN_SHIFT     = 4;

    // The checksummed region is the option-less header as 16-bit words.
    localparam int unsigned CSUM_WORDS     = IP_HDR_BYTES / 2;

    typedef enum logic [1:0] {
        WAIT_W0,
        WAIT_W1,
        SKIP
    } state_t;

    typedef struct packed {
        logic [31:0] daddr;
        logic        is_ipv4;
        logic        csum_ok;
    } result_t;

endpackage

// File: rtl/ipv4_daddr_extract_csum.sv
// ipv4_hdr_csum: combinational ones'-complement sum of CSUM_WORDS 16-bit
// words with end-around carry. A correct IPv4 header sums to 16'hFFFF.
//
// Ports:
//   words : header words, first word in the most significant 16 bits
//   sum   : folded 16-bit ones'-complement sum
module ipv4_hdr_csum
    import ipv4_pkg::*;
(
    input  logic [CSUM_WORDS*16-1:0] words,
    output logic [15:0]              sum
);

    localparam int unsigned ACC_W = 16 + $clog2(CSUM_WORDS);

    logic [ACC_W-1:0] acc;
    logic [16:0]      fold;

    // Two folds are enough: the first leaves at most a 1-bit carry, and when
    // that carry is set the low half is tiny, so the second fold cannot carry.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < CSUM_WORDS; i++) begin
            acc = acc + ACC_W'(words[i*16 +: 16]);
        end
        fold = 17'(acc[15:0]) + 17'(acc[ACC_W-1:16]);
        sum  = fold[15:0] + 16'(fold[16]);
    end

endmodule

// File: rtl/ipv4_daddr_extract.sv
// ipv4_daddr_extract: passive AXI4-Stream tap that extracts the IPv4
// destination address of every frame and classifies it (IPv4 / not,
// header checksum). Never drives tready; observes tvalid & tready beats only.
//
// Build option: define IPV4_DADDR_EXTRACT_VLAN_EN to parse one 802.1Q tag
// (ethertype 0x8100); otherwise tagged frames are reported as non-IPv4.
//
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   s_axis_*            : observed ingress stream (tready is an input)
//   o_ipv4_daddr        : destination address, held until the next result
//   o_ipv4_daddr_valid  : one-cycle pulse, one per frame
//   o_is_ipv4, o_csum_ok: classification, qualified by the valid pulse
//   o_pkt_cnt           : frames seen
//   o_non_ipv4_cnt      : frames reported with o_is_ipv4 = 0
module ipv4_daddr_extract
    import ipv4_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int C_CNT_WIDTH         = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                             s_axis_tvalid,
    input  logic                             s_axis_tready,
    input  logic                             s_axis_tlast,
    output logic [31:0]                      o_ipv4_daddr,
    output logic                             o_ipv4_daddr_valid,
    output logic                             o_is_ipv4,
    output logic                             o_csum_ok,
    output logic [C_CNT_WIDTH-1:0]           o_pkt_cnt,
    output logic [C_CNT_WIDTH-1:0]           o_non_ipv4_cnt
);

    localparam int unsigned DW        = C_S_AXIS_DATA_WIDTH;
    // Beat-0 capture holds frame bytes ETH_TYPE_OFF..31.
    localparam int unsigned CAP_W     = (BEAT_BYTES - ETH_TYPE_OFF) * 8;
    localparam int unsigned ETYPE_MSB = CAP_W - 1;
    localparam int unsigned HDR_W     = IP_HDR_BYTES * 8;
    // Header bytes found in beat 0 and the remainder taken from beat 1.
    localparam int unsigned HDR_CAP_W = (BEAT_BYTES - IP_HDR_OFF) * 8;
    localparam int unsigned HDR_W1_W  = HDR_W - HDR_CAP_W;
    // tkeep bit (MSB = byte 0) of the last header byte within beat 1.
    localparam int unsigned KEEP_END  = 2*BEAT_BYTES - IP_HDR_OFF - IP_HDR_BYTES;
    localparam int unsigned DADDR_LSB = (IP_HDR_OFF + IP_HDR_BYTES - IP_DADDR_OFF - 4) * 8;
`ifdef IPV4_DADDR_EXTRACT_VLAN_EN
    localparam int unsigned INNER_ETYPE_MSB = ETYPE_MSB - VLAN_SHIFT*8;
    localparam int unsigned VHDR_CAP_W      = HDR_CAP_W - VLAN_SHIFT*8;
    localparam int unsigned VHDR_W1_W       = HDR_W1_W + VLAN_SHIFT*8;
    localparam int unsigned VKEEP_END       = KEEP_END - VLAN_SHIFT;
`endif
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE = 1;

    if (C_S_AXIS_DATA_WIDTH != 256) begin : g_bad_width
        $error("ipv4_daddr_extract supports only a 256-bit data width");
    end

    logic             beat;
    state_t           state_q, state_d;
    logic             drop_q, drop_d;
    logic             cap_en;
    logic             emit;
    logic             runt;
    logic [CAP_W-1:0] cap_q;

    logic [15:0]      etype;
    logic [HDR_W-1:0] hdr;
    logic             keep_ok;
    logic [3:0]       version;
    logic [3:0]       ihl;
    logic             hdr_ipv4;
    logic [15:0]      csum_sum;
    result_t          res_d;

    // Only the header-end byte enable matters; the rest are don't-care.
    logic             unused_keep;
    assign unused_keep = ^s_axis_tkeep;

    assign beat = s_axis_tvalid & s_axis_tready;

    // drop_q marks that reset cut a frame short: the bus is still inside
    // that frame, so its remaining beats must not be parsed as a new header.
    // It keeps tracking frame boundaries while reset is held.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= WAIT_W0;
            cap_q   <= '0;
            if (beat) begin
                drop_q <= !s_axis_tlast;
            end else if (state_q != WAIT_W0) begin
                drop_q <= 1'b1;
            end
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            if (cap_en) begin
                cap_q <= s_axis_tdata[CAP_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        cap_en  = 1'b0;
        emit    = 1'b0;
        runt    = 1'b0;
        case (state_q)
            WAIT_W0: begin
                if (beat) begin
                    if (drop_q) begin
                        drop_d = 1'b0;
                        if (!s_axis_tlast) begin
                            state_d = SKIP;
                        end
                    end else begin
                        cap_en = 1'b1;
                        if (s_axis_tlast) begin
                            emit = 1'b1;
                            runt = 1'b1;
                        end else begin
                            state_d = WAIT_W1;
                        end
                    end
                end
            end
            WAIT_W1: begin
                if (beat) begin
                    emit    = 1'b1;
                    state_d = s_axis_tlast ? WAIT_W0 : SKIP;
                end
            end
            SKIP: begin
                if (beat && s_axis_tlast) begin
                    state_d = WAIT_W0;
                end
            end
            default: state_d = WAIT_W0;
        endcase
    end

    // Assemble the 20-byte IPv4 header from the beat-0 capture and the
    // leading bytes of the beat currently on the bus (beat 1).
    always_comb begin
        etype   = cap_q[ETYPE_MSB -: 16];
        hdr     = {cap_q[HDR_CAP_W-1:0], s_axis_tdata[DW-1 -: HDR_W1_W]};
        keep_ok = s_axis_tkeep[KEEP_END];
`ifdef IPV4_DADDR_EXTRACT_VLAN_EN
        if (cap_q[ETYPE_MSB -: 16] == ETHERTYPE_VLAN) begin
            etype   = cap_q[INNER_ETYPE_MSB -: 16];
            hdr     = {cap_q[VHDR_CAP_W-1:0], s_axis_tdata[DW-1 -: VHDR_W1_W]};
            keep_ok = s_axis_tkeep[VKEEP_END];
        end
`endif
    end

    ipv4_hdr_csum u_csum (
        .words (hdr),
        .sum   (csum_sum)
    );

    always_comb begin
        version  = hdr[HDR_W-1 -: 4];
        ihl      = hdr[HDR_W-5 -: 4];
        hdr_ipv4 = (etype == ETHERTYPE_IPV4) && (version == 4'd4) &&
                   (ihl >= 4'd5) && keep_ok;
        res_d    = '0;
        if (!runt) begin
            res_d.is_ipv4 = hdr_ipv4;
            res_d.csum_ok = hdr_ipv4 && (ihl == 4'd5) && (csum_sum == 16'hFFFF);
            res_d.daddr   = hdr_ipv4 ? hdr[DADDR_LSB +: 32] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            o_ipv4_daddr       <= '0;
            o_ipv4_daddr_valid <= 1'b0;
            o_is_ipv4          <= 1'b0;
            o_csum_ok          <= 1'b0;
            o_pkt_cnt          <= '0;
            o_non_ipv4_cnt     <= '0;
        end else begin
            o_ipv4_daddr_valid <= emit;
            if (emit) begin
                o_ipv4_daddr <= res_d.daddr;
                o_is_ipv4    <= res_d.is_ipv4;
                o_csum_ok    <= res_d.csum_ok;
                o_pkt_cnt    <= o_pkt_cnt + CNT_ONE;
                if (!res_d.is_ipv4) begin
                    o_non_ipv4_cnt <= o_non_ipv4_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ipv4_daddr_extract.sv
// Bench for ipv4_daddr_extract: directed steps followed by random frames,
// each result checked against a byte-level reference model.
module tb_ipv4_daddr_extract;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tready;
    logic         s_axis_tlast;
    logic [31:0]  o_ipv4_daddr;
    logic         o_ipv4_daddr_valid;
    logic         o_is_ipv4;
    logic         o_csum_ok;
    logic [31:0]  o_pkt_cnt;
    logic [31:0]  o_non_ipv4_cnt;

    always #5 clk = ~clk;

    ipv4_daddr_extract #(
        .C_S_AXIS_DATA_WIDTH (256),
        .C_CNT_WIDTH         (32)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tkeep       (s_axis_tkeep),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tready      (s_axis_tready),
        .s_axis_tlast       (s_axis_tlast),
        .o_ipv4_daddr       (o_ipv4_daddr),
        .o_ipv4_daddr_valid (o_ipv4_daddr_valid),
        .o_is_ipv4          (o_is_ipv4),
        .o_csum_ok          (o_csum_ok),
        .o_pkt_cnt          (o_pkt_cnt),
        .o_non_ipv4_cnt     (o_non_ipv4_cnt)
    );

    typedef struct {
        logic [31:0] daddr;
        logic        ip;
        logic        ok;
        logic [31:0] pc;
        logic [31:0] nc;
        int unsigned cyc;
    } res_t;

    res_t        exp_q[$];
    res_t        got_q[$];
    logic [7:0]  frm[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned cyc   = 0;
    logic [31:0] exp_pkt = '0;
    logic [31:0] exp_non = '0;

    localparam logic [159:0] PLAN_HDR = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
    localparam logic [159:0] BAD_HDR  = 160'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8_00c7;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        res_t r;
        if (o_ipv4_daddr_valid === 1'b1) begin
            r.daddr = o_ipv4_daddr;
            r.ip    = o_is_ipv4;
            r.ok    = o_csum_ok;
            r.pc    = o_pkt_cnt;
            r.nc    = o_non_ipv4_cnt;
            r.cyc   = cyc;
            got_q.push_back(r);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gb(input int unsigned i);
        return (i < frm.size()) ? frm[i] : 8'h00;
    endfunction

    // Ones'-complement sum of the ten header words starting at frame byte off.
    function automatic logic [15:0] ocsum(input int unsigned off);
        int unsigned s = 0;
        for (int unsigned w = 0; w < 10; w++) s += {gb(off + 2*w), gb(off + 2*w + 1)};
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        return s[15:0];
    endfunction

    task automatic push_exp(input logic [31:0] da, input logic ip, input logic ok);
        res_t r;
        exp_pkt++;
        if (!ip) exp_non++;
        r.daddr = da; r.ip = ip; r.ok = ok; r.pc = exp_pkt; r.nc = exp_non; r.cyc = 0;
        exp_q.push_back(r);
    endtask

    // Reference model working on the frame bytes directly.
    task automatic model_exp();
        int unsigned len = frm.size();
        int unsigned off = 14;
        logic [15:0] et;
        logic [7:0]  vi;
        logic        ip = 1'b0;
        logic        ok = 1'b0;
        logic [31:0] da = '0;
        if (len > 32) begin
            et = {gb(12), gb(13)};
`ifdef IPV4_DADDR_EXTRACT_VLAN_EN
            if (et == 16'h8100) begin
                et  = {gb(16), gb(17)};
                off = 18;
            end
`endif
            vi = gb(off);
            ip = (et == 16'h0800) && (vi[7:4] == 4'd4) && (vi[3:0] >= 4'd5) && (len >= off + 20);
            if (ip) begin
                ok = (vi[3:0] == 4'd5) && (ocsum(off) == 16'hFFFF);
                da = {gb(off + 16), gb(off + 17), gb(off + 18), gb(off + 19)};
            end
        end
        push_exp(da, ip, ok);
    endtask

    task automatic build_fixed(input logic [159:0] h, input int unsigned len);
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
        frm.push_back(8'h08); frm.push_back(8'h00);
        for (int i = 0; i < 20; i++) frm.push_back(h[159 - 8*i -: 8]);
        while (frm.size() < len) frm.push_back(8'($urandom));
    endtask

    task automatic build_ip(input logic [7:0] vi, input logic [31:0] da, input bit vlan,
                            input int unsigned len, input bit corrupt, input logic [15:0] et);
        int unsigned hs;
        logic [15:0] c;
        logic [31:0] sa;
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
        if (vlan) begin
            frm.push_back(8'h81); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h05);
        end
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        hs = frm.size();
        sa = $urandom;
        frm.push_back(vi); frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h54);
        frm.push_back(8'($urandom)); frm.push_back(8'($urandom));
        frm.push_back(8'h40); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h11);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int i = 0; i < 4; i++) frm.push_back(sa[31 - 8*i -: 8]);
        for (int i = 0; i < 4; i++) frm.push_back(da[31 - 8*i -: 8]);
        c = ~ocsum(hs);
        c[0] = c[0] ^ corrupt;
        frm[hs + 10] = c[15:8];
        frm[hs + 11] = c[7:0];
        while (frm.size() < len) frm.push_back(8'($urandom));
        while (frm.size() > len) void'(frm.pop_back());
    endtask

    task automatic idle(input int unsigned n);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tready = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Drives beats kf..kl of frm; bp toggles tready 1,0,1,0... per cycle.
    task automatic send_beats(input int unsigned kf, input int unsigned kl, input bit bp);
        int unsigned nb = (frm.size() + 31) / 32;
        bit rdy = 1'b1;
        for (int unsigned k = kf; k <= kl; k++) begin
            for (int unsigned i = 0; i < 32; i++) begin
                s_axis_tdata[255 - 8*i -: 8] = gb(32*k + i);
                s_axis_tkeep[31 - i]         = (32*k + i) < frm.size();
            end
            s_axis_tvalid = 1'b1;
            s_axis_tlast  = (k == nb - 1);
            do begin
                s_axis_tready = bp ? rdy : 1'b1;
                rdy = !rdy;
                @(posedge clk); #1;
            end while (!s_axis_tready);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b1;
    endtask

    task automatic send_frame(input bit bp);
        send_beats(0, (frm.size() + 31) / 32 - 1, bp);
    endtask

    task automatic drain(input string tag, input bit chk_gap);
        int unsigned n;
        res_t g, e;
        for (int unsigned t = 0; t < 40 && got_q.size() < exp_q.size(); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check({tag, "_npulse"}, got_q.size(), exp_q.size());
        if (chk_gap) check({tag, "_gap"}, (got_q.size() >= 2) ? got_q[1].cyc - got_q[0].cyc : 0, 1);
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int unsigned i = 0; i < n; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_daddr"}, g.daddr, e.daddr);
            check({tag, "_is_ipv4"}, 32'(g.ip), 32'(e.ip));
            check({tag, "_csum_ok"}, 32'(g.ok), 32'(e.ok));
            check({tag, "_pkt_cnt"}, g.pc, e.pc);
            check({tag, "_non_cnt"}, g.nc, e.nc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int unsigned kind, len;
        bit vlan, corrupt;
        logic [7:0] vi;
        logic [15:0] et;

        // Reset held with one-beat frames streaming past.
        reset         = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tready = 1'b1;
        s_axis_tlast  = 1'b1;
        s_axis_tkeep  = '1;
        s_axis_tdata  = {8{$urandom}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_daddr", o_ipv4_daddr, 0);
            check("rst_valid", 32'(o_ipv4_daddr_valid), 0);
            check("rst_is_ipv4", 32'(o_is_ipv4), 0);
            check("rst_csum_ok", 32'(o_csum_ok), 0);
            check("rst_pkt_cnt", o_pkt_cnt, 0);
            check("rst_non_cnt", o_non_ipv4_cnt, 0);
            s_axis_tdata = {8{$urandom}};
        end
        @(posedge clk); #1;
        reset = 1'b1;
        idle(3);
        check("idle_pkt_cnt", o_pkt_cnt, 0);
        check("idle_non_cnt", o_non_ipv4_cnt, 0);
        check("idle_pulses", got_q.size(), 0);

        // Valid IPv4, three beats.
        build_fixed(PLAN_HDR, 80);
        push_exp(32'hC0A800C7, 1'b1, 1'b1);
        send_frame(1'b0);
        drain("ipv4", 1'b0);

        // Same frame with a corrupted checksum byte.
        build_fixed(BAD_HDR, 80);
        push_exp(32'hC0A800C7, 1'b1, 1'b0);
        send_frame(1'b0);
        drain("badcsum", 1'b0);

        // ARP (2 beats) followed immediately by a one-beat runt.
        build_ip(8'h45, $urandom, 1'b0, 60, 1'b0, 16'h0806);
        push_exp(32'h0, 1'b0, 1'b0);
        send_frame(1'b0);
        build_ip(8'h45, $urandom, 1'b0, 20, 1'b0, 16'h0800);
        push_exp(32'h0, 1'b0, 1'b0);
        send_frame(1'b0);
        drain("arp_runt", 1'b1);

        // tready toggling during the frame.
        build_fixed(PLAN_HDR, 80);
        push_exp(32'hC0A800C7, 1'b1, 1'b1);
        send_frame(1'b1);
        drain("bp", 1'b0);

        // Reset while in WAIT_W1: rest of the frame is skipped.
        build_fixed(PLAN_HDR, 80);
        send_beats(0, 0, 1'b0);
        reset = 1'b0;
        idle(2);
        check("midrst_pkt_cnt", o_pkt_cnt, 0);
        check("midrst_valid", 32'(o_ipv4_daddr_valid), 0);
        reset = 1'b1;
        exp_pkt = '0;
        exp_non = '0;
        got_q.delete();
        send_beats(1, 2, 1'b0);
        idle(2);
        drain("midrst_skip", 1'b0);
        build_fixed(PLAN_HDR, 80);
        push_exp(32'hC0A800C7, 1'b1, 1'b1);
        send_frame(1'b0);
        drain("after_rst", 1'b0);

        // VLAN-tagged IPv4 to 10.0.0.1.
        build_ip(8'h45, 32'h0A000001, 1'b1, 80, 1'b0, 16'h0800);
`ifdef IPV4_DADDR_EXTRACT_VLAN_EN
        push_exp(32'h0A000001, 1'b1, 1'b1);
`else
        push_exp(32'h0, 1'b0, 1'b0);
`endif
        send_frame(1'b0);
        drain("vlan", 1'b0);

        // Random frames, sometimes back-to-back, sometimes with backpressure.
        for (int n = 0; n < 40; n++) begin
            kind    = $urandom_range(0, 9);
            vlan    = (kind == 9);
            corrupt = (kind == 5);
            vi      = (kind == 6) ? 8'h46 : (kind == 7) ? (($urandom_range(0, 1) != 0) ? 8'h65 : 8'h44) : 8'h45;
            et      = 16'h0800;
            if (kind == 8) begin
                case ($urandom_range(0, 2))
                    0: et = 16'h0806;
                    1: et = 16'h86DD;
                    default: et = 16'h8100;
                endcase
            end
            len = vlan ? $urandom_range(38, 130) : $urandom_range(34, 130);
            if (kind == 3) len = 33;
            if (kind == 4) len = $urandom_range(1, 32);
            build_ip(vi, $urandom, vlan, len, corrupt, et);
            model_exp();
            send_frame($urandom_range(0, 1) != 0);
            if ($urandom_range(0, 3) == 0) begin
                idle($urandom_range(1, 3));
                drain("rand", 1'b0);
            end
        end
        idle(2);
        drain("rand_end", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ipv4_daddr_extract.md
Name: ipv4_daddr_extract

Overview:
- Passive AXI4-Stream tap on the ingress packet bus of the router output-port-lookup pipeline.
- Per packet, extracts the IPv4 destination address and classifies the frame (IPv4 / non-IPv4, header checksum).
- Feeds the local-address LUT stage through its daddr/daddr_valid inputs.
- Never backpressures the bus; observes only beats where tvalid & tready.

Parameters:
- C_S_AXIS_DATA_WIDTH, 256, TDATA width. Only 256 is supported.
- C_CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- s_axis_tdata  in  256  frame data; frame byte 0 = tdata[255:248], byte 31 = tdata[7:0]
- s_axis_tkeep  in  32  byte enables, MSB = byte 0
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  in  1  beat ready (observed only, not driven)
- s_axis_tlast  in  1  last beat of frame
- o_ipv4_daddr  out  32  extracted destination address
- o_ipv4_daddr_valid  out  1  one-cycle pulse, exactly one per frame
- o_is_ipv4  out  1  frame is well-formed IPv4; qualified by valid
- o_csum_ok  out  1  IPv4 header checksum correct; qualified by valid
- o_pkt_cnt  out  C_CNT_WIDTH  frames seen
- o_non_ipv4_cnt  out  C_CNT_WIDTH  frames with o_is_ipv4 = 0

Behaviour:
- Beat accepted = s_axis_tvalid & s_axis_tready. All state advances only on accepted beats.
- Reset (reset == 0 at posedge clk):
  - all outputs 0; counters 0; FSM to WAIT_W0.
  - A packet in flight is abandoned. Its remaining beats are treated as an in-progress packet: the FSM enters SKIP on the first non-tlast beat until tlast; no result is emitted.
- FSM states:
  - WAIT_W0:
    - On accepted beat, capture bytes 12..31: ethertype [12:13], ver/IHL [14], header bytes 14..31 for checksum, daddr bytes 30..31.
    - tlast=1 → emit runt result (is_ipv4=0, csum_ok=0, daddr=0); stay in WAIT_W0.
    - Else → WAIT_W1.
  - WAIT_W1:
    - On accepted beat, capture bytes 32..33, completing daddr = bytes 30..33 in network order; daddr byte 30 lands in o_ipv4_daddr[31:24].
    - Emit result.
    - tlast=1 → WAIT_W0; else → SKIP.
  - SKIP: on accepted beat with tlast=1 → WAIT_W0.
- Result is registered. o_ipv4_daddr_valid rises in the cycle after the accepted beat that completes the header, and stays high for exactly 1 cycle.
- o_ipv4_daddr holds its value until the next emit.
- o_is_ipv4 = 1 iff all of the following hold; otherwise o_ipv4_daddr = 0.
  - ethertype == 0x0800
  - version == 4
  - IHL >= 5
  - tkeep covers byte 33
- o_csum_ok:
  - Ones'-complement 16-bit sum of header bytes 14..33 (ten 16-bit words) equals 0xFFFF.
  - Forced 0 if IHL != 5 (options not checked) or if is_ipv4 = 0.
- Counters:
  - o_pkt_cnt increments on every emit.
  - o_non_ipv4_cnt increments on emits with is_ipv4 = 0.
  - Both wrap modulo 2^C_CNT_WIDTH and update in the same cycle as the valid pulse.
- Back-to-back frames: tlast followed by the next frame's beat 0 in the next cycle must be handled with no bubble. Successive valid pulses may occur on consecutive cycles.
- tvalid low mid-frame: state holds; no timeout.

Optional Feature:
- Macro: IPV4_DADDR_EXTRACT_VLAN_EN.
- Defined:
  - If bytes 12..13 == 0x8100, the inner ethertype is taken at bytes 16..17.
  - All IPv4 offsets shift by +4: header 18..37, daddr 34..37, both captured in WAIT_W1.
  - tkeep must cover byte 37.
  - A VLAN-tagged frame that is tlast on beat 0 is a runt.
- Undefined: 0x8100 frames are non-IPv4.

Decomposition:
- Package ipv4_pkg holds:
  - ETHERTYPE_IPV4 (0x0800), ETHERTYPE_VLAN (0x8100)
  - byte offsets (ETH_TYPE_OFF, IP_HDR_OFF, IP_DADDR_OFF, VLAN_SHIFT)
  - FSM state encoding (WAIT_W0, WAIT_W1, SKIP)
- Sub-module ipv4_hdr_csum: combinational ones'-complement sum of ten 16-bit words with end-around carry. Outputs the 16-bit sum. Instantiated once in front of the result register.

Test Plan:
- Reset and idle:
  - Hold reset=0 for 4 cycles with tvalid=1 → all outputs 0, no valid pulse.
  - Release reset → counters 0.
- Valid IPv4, 3 beats:
  - Header 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7 → one pulse 1 cycle after beat 1.
  - daddr=0xC0A800C7, is_ipv4=1, csum_ok=1, pkt_cnt=1.
- Same frame with checksum byte corrupted to b862 → is_ipv4=1, csum_ok=0.
- Non-IPv4 frames:
  - ARP frame (ethertype 0x0806), 2 beats, back-to-back with a 1-beat runt (tlast on beat 0) → two pulses.
  - Both have is_ipv4=0, daddr=0; non_ipv4_cnt=2.
  - No bubble between frames.
- Backpressure and mid-frame reset:
  - tready toggling 1010 during frame → result is identical to the unstalled case.
  - Reset asserted in WAIT_W1 → no pulse for that frame.
  - Remaining beats skipped; next frame is parsed correctly.
- VLAN, with IPV4_DADDR_EXTRACT_VLAN_EN defined:
  - Tag 0x8100, VID 5, inner IPv4 to 10.0.0.1 → daddr=0x0A000001, is_ipv4=1.
  - With the macro undefined → is_ipv4=0.
